scroll_scheduler: RTL and testbench

- Sequences world scrolling for the stickman runner.
- Converts the ~60 Hz frame_clk into single-cycle frame ticks and advances frame_counter by the current scroll speed while the game is in PLAY.
- Ramps speed over time, supports pause via keyboard and raises level_done when the level length is reached.
- Sits between the keyboard/VGA timing and game_logic/background, which consume frame_counter and level_done.

---
 rtl/stickman_pkg.sv | 23 ++
 rtl/scroll_scheduler_if.sv | 32 +++
 rtl/rise_detect.sv | 25 ++
 rtl/scroll_scheduler.sv | 136 +++++++++++++
 tb/tb_scroll_scheduler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/stickman_pkg.sv
// stickman_pkg: definitions shared across the stickman runner blocks.
//   - One-hot game status codes driven by game_logic.
//   - Keyboard scancodes the game reacts to.
//   - State encoding of the scroll scheduler.
package stickman_pkg;

  localparam logic [3:0] ST_WAIT = 4'b1000;
  localparam logic [3:0] ST_PLAY = 4'b0100;
  localparam logic [3:0] ST_WIN  = 4'b0010;
  localparam logic [3:0] ST_LOSE = 4'b0001;

  localparam logic [7:0] KEY_SPACE = 8'h2c;
  localparam logic [7:0] KEY_P     = 8'h13;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE,
    FROZEN
  } sched_state_t;

endpackage

// File: rtl/scroll_scheduler_if.sv
// scroll_scheduler_if: scroll state published by the scheduler.
//   frame_counter [11:0] world scroll position
//   scroll_speed  [3:0]  current speed in pixels/frame
//   frame_tick           one-Clk pulse per new frame
//   paused               high while the game is paused
//   level_done           high while the level end has been reached
// master: the scheduler (drives everything); slave: game_logic/background.
interface scroll_scheduler_if;

  logic [11:0] frame_counter;
  logic [3:0]  scroll_speed;
  logic        frame_tick;
  logic        paused;
  logic        level_done;

  modport master (
    output frame_counter,
    output scroll_speed,
    output frame_tick,
    output paused,
    output level_done
  );

  modport slave (
    input frame_counter,
    input scroll_speed,
    input frame_tick,
    input paused,
    input level_done
  );

endinterface

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge pulse generator.
//   Clk     in   system clock
//   Reset_n in   asynchronous active-low reset
//   din     in   level to watch (synchronous to Clk)
//   pulse   out  high for one Clk after a 0->1 change of din is sampled
module rise_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= din;
      pulse <= din & ~prev;
    end
  end

endmodule

// File: rtl/scroll_scheduler.sv
// scroll_scheduler: sequences world scrolling for the stickman runner.
//   Clk        in   50 MHz system clock
//   Reset_n    in   asynchronous active-low reset
//   frame_clk  in   ~60 Hz new-frame level, synchronous to Clk
//   keycode    in   last received key
//   status     in   one-hot game status {wait, play, win, lose}
//   bus        out  scroll_scheduler_if.master: frame_counter, scroll_speed,
//                   frame_tick, paused, level_done (all registered)
module scroll_scheduler
  import stickman_pkg::*;
#(
  parameter logic [11:0] LEVEL_LEN   = 12'd3600,
  parameter logic [3:0]  SPEED_INIT  = 4'd1,
  parameter logic [3:0]  SPEED_MAX   = 4'd6,
  parameter logic [9:0]  RAMP_FRAMES = 10'd600,
  parameter logic [7:0]  PAUSE_KEY   = KEY_P
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic [7:0]          keycode,
  input  logic [3:0]          status,
  scroll_scheduler_if.master  bus
);

  sched_state_t state;
  logic [11:0]  counter;
  logic [3:0]   speed;
  logic [9:0]   ramp;
  logic         paused_q;
  logic         done_q;
  logic         frame_tick;
  logic         pause_press;
  logic         key_match;
  logic         status_ok;
  logic [12:0]  sum;
  logic [3:0]   speed_next;

  assign key_match = (keycode == PAUSE_KEY);

  rise_detect u_frame_edge (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .din     (frame_clk),
    .pulse   (frame_tick)
  );

  rise_detect u_pause_edge (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .din     (key_match),
    .pulse   (pause_press)
  );

  // Anything that is not exactly one status bit freezes the scheduler in place.
  assign status_ok = (status == ST_WAIT) || (status == ST_PLAY) ||
                     (status == ST_WIN)  || (status == ST_LOSE);

  // 13-bit sum so the level-end compare cannot be fooled by a 12-bit wrap.
  assign sum        = {1'b0, counter} + {9'd0, speed};
  assign speed_next = (speed >= SPEED_MAX) ? SPEED_MAX : speed + 4'd1;

  // Status is decoded ahead of the per-state logic so a status change always
  // beats a frame tick or pause press landing on the same Clk.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      counter  <= 12'd0;
      speed    <= SPEED_INIT;
      ramp     <= 10'd0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (status == ST_WAIT) begin
      state    <= IDLE;
      counter  <= 12'd0;
      speed    <= SPEED_INIT;
      ramp     <= 10'd0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (status_ok) begin
      case (state)
        IDLE: begin
          if (status == ST_PLAY) state <= RUN;
        end
        RUN: begin
          if (status != ST_PLAY) begin
            state <= FROZEN;
          end else if (pause_press) begin
            state    <= PAUSED;
            paused_q <= 1'b1;
          end else if (frame_tick) begin
            if (sum >= {1'b0, LEVEL_LEN}) begin
              counter <= LEVEL_LEN;
              state   <= DONE;
              done_q  <= 1'b1;
            end else begin
              counter <= counter + {8'd0, speed};
              if (ramp == RAMP_FRAMES - 10'd1) begin
                ramp  <= 10'd0;
                speed <= speed_next;
              end else begin
                ramp <= ramp + 10'd1;
              end
            end
          end
        end
        PAUSED: begin
          if (status != ST_PLAY) begin
            state    <= FROZEN;
            paused_q <= 1'b0;
          end else if (pause_press) begin
            state    <= RUN;
            paused_q <= 1'b0;
          end
        end
        DONE: begin
          if (status != ST_PLAY) begin
            state  <= FROZEN;
            done_q <= 1'b0;
          end
        end
        FROZEN: begin
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.frame_counter = counter;
  assign bus.scroll_speed  = speed;
  assign bus.frame_tick    = frame_tick;
  assign bus.paused        = paused_q;
  assign bus.level_done    = done_q;

endmodule

// File: tb/tb_scroll_scheduler.sv
// tb_scroll_scheduler: directed bench for scroll_scheduler with a short level
// (LEVEL_LEN=20, RAMP_FRAMES=4, SPEED_INIT=1, SPEED_MAX=3).
module tb_scroll_scheduler;
  import stickman_pkg::*;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [3:0] status;

  int check_count = 0;
  int pass_count  = 0;

  scroll_scheduler_if bus ();

  scroll_scheduler #(
    .LEVEL_LEN   (12'd20),
    .SPEED_INIT  (4'd1),
    .SPEED_MAX   (4'd3),
    .RAMP_FRAMES (10'd4),
    .PAUSE_KEY   (8'h13)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .status    (status),
    .bus       (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       pulse;
    logic [3:0] st;
    int         exp_counter;
    int         exp_speed;
    int         exp_done;
  } vec_t;

  vec_t vecs[15];

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One frame_clk pulse: tick registers on the first edge, counter moves on the second.
  task automatic pulse_frame();
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    step(1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    status  = v.st;
    keycode = 8'h00;
    if (v.pulse) pulse_frame();
    else step(2);
  endtask

  task automatic check_state(input string name, input int c, input int s,
                             input int p, input int d);
    check_output({name, ".counter"}, int'(bus.frame_counter), c);
    check_output({name, ".speed"},   int'(bus.scroll_speed), s);
    check_output({name, ".paused"},  int'(bus.paused), p);
    check_output({name, ".done"},    int'(bus.level_done), d);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, ST_PLAY, 0,  1, 0};
    vecs[1]  = '{1'b1, ST_PLAY, 1,  1, 0};
    vecs[2]  = '{1'b1, ST_PLAY, 2,  1, 0};
    vecs[3]  = '{1'b1, ST_PLAY, 3,  1, 0};
    vecs[4]  = '{1'b1, ST_PLAY, 4,  2, 0};
    vecs[5]  = '{1'b1, ST_PLAY, 6,  2, 0};
    vecs[6]  = '{1'b1, ST_PLAY, 8,  2, 0};
    vecs[7]  = '{1'b1, ST_PLAY, 10, 2, 0};
    vecs[8]  = '{1'b1, ST_PLAY, 12, 3, 0};
    vecs[9]  = '{1'b1, ST_PLAY, 15, 3, 0};
    vecs[10] = '{1'b1, ST_PLAY, 18, 3, 0};
    vecs[11] = '{1'b1, ST_PLAY, 20, 3, 1};
    vecs[12] = '{1'b1, ST_PLAY, 20, 3, 1};
    vecs[13] = '{1'b0, ST_WIN,  20, 3, 0};
    vecs[14] = '{1'b0, ST_WAIT, 0,  1, 0};

    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    status    = ST_WAIT;
    step(2);
    check_state("reset", 0, 1, 0, 0);
    check_output("reset.tick", int'(bus.frame_tick), 0);
    Reset_n = 1'b1;
    step(2);
    check_state("idle_hold", 0, 1, 0, 0);

    // Full run: ramp, clamp at level end, freeze on win, reinit on wait.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d.counter", i), int'(bus.frame_counter), vecs[i].exp_counter);
      check_output($sformatf("vec%0d.speed", i),   int'(bus.scroll_speed),  vecs[i].exp_speed);
      check_output($sformatf("vec%0d.done", i),    int'(bus.level_done),    vecs[i].exp_done);
    end

    // frame_tick width and latency; a held-high frame_clk gives one tick.
    status = ST_PLAY;
    step(2);
    frame_clk = 1'b1;
    step(1);
    check_output("tick.first", int'(bus.frame_tick), 1);
    check_output("tick.counter_before", int'(bus.frame_counter), 0);
    step(1);
    check_output("tick.second", int'(bus.frame_tick), 0);
    check_output("tick.counter_after", int'(bus.frame_counter), 1);
    step(1);
    check_output("tick.held", int'(bus.frame_tick), 0);
    check_output("tick.counter_held", int'(bus.frame_counter), 1);
    frame_clk = 1'b0;
    step(1);

    // Pause held ~1000 Clk: one press, ticks ignored.
    keycode = 8'h13;
    step(2);
    check_output("pause.on", int'(bus.paused), 1);
    for (int i = 0; i < 5; i++) pulse_frame();
    step(980);
    check_state("pause.held", 1, 1, 1, 0);
    keycode = 8'h00;
    step(2);
    check_output("pause.release", int'(bus.paused), 1);
    keycode = 8'h13;
    step(2);
    check_output("pause.off", int'(bus.paused), 0);
    keycode = 8'h00;
    step(1);
    pulse_frame();
    check_output("pause.resume_tick", int'(bus.frame_counter), 2);

    // Pause press coinciding with a tick: the tick is discarded.
    frame_clk = 1'b1;
    keycode   = 8'h13;
    step(1);
    frame_clk = 1'b0;
    step(1);
    check_state("pause.coincide", 2, 1, 1, 0);
    keycode = 8'h00;
    step(2);
    keycode = 8'h13;
    step(2);
    keycode = 8'h00;
    step(1);
    check_output("pause.coincide_off", int'(bus.paused), 0);
    pulse_frame();
    check_output("pause.after_coincide", int'(bus.frame_counter), 3);

    // Win while paused clears paused and freezes.
    keycode = 8'h13;
    step(2);
    keycode = 8'h00;
    status  = ST_WIN;
    step(2);
    check_state("paused_win", 3, 1, 0, 0);
    status = ST_WAIT;
    step(2);
    check_state("reinit1", 0, 1, 0, 0);

    // Non-one-hot status holds; lose coinciding with a tick is not applied.
    status = ST_PLAY;
    step(2);
    pulse_frame();
    check_output("onehot.start", int'(bus.frame_counter), 1);
    status = 4'b0000;
    pulse_frame();
    check_output("onehot.zero", int'(bus.frame_counter), 1);
    status = 4'b0110;
    pulse_frame();
    check_output("onehot.multi", int'(bus.frame_counter), 1);
    status = ST_PLAY;
    pulse_frame();
    check_output("onehot.resume", int'(bus.frame_counter), 2);
    frame_clk = 1'b1;
    step(1);
    status    = ST_LOSE;
    frame_clk = 1'b0;
    step(1);
    check_output("lose.coincide", int'(bus.frame_counter), 2);
    pulse_frame();
    check_output("lose.frozen", int'(bus.frame_counter), 2);
    status = ST_WAIT;
    step(2);
    check_state("reinit2", 0, 1, 0, 0);

    // Asynchronous reset mid-run while paused.
    status = ST_PLAY;
    step(2);
    for (int i = 0; i < 5; i++) pulse_frame();
    check_state("mid_run", 6, 2, 0, 0);
    keycode = 8'h13;
    step(2);
    check_output("mid_run.paused", int'(bus.paused), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_state("async_reset", 0, 1, 0, 0);
    check_output("async_reset.tick", int'(bus.frame_tick), 0);
    status  = ST_WAIT;
    keycode = 8'h00;
    step(1);
    Reset_n = 1'b1;
    step(3);
    check_state("post_reset_idle", 0, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
